// File: rtl/tcp_buf_pkg.sv
// rtl/tcp_buf_pkg.sv - shared buffer defaults, address-width helper and reader FSM encoding
// Contents: MEM_DEPTH_DEF, DATA_BITS_DEF, SEG_WORDS_DEF, addr_width(), rd_state_t
package tcp_buf_pkg;

    localparam int MEM_DEPTH_DEF = 1024;
    localparam int DATA_BITS_DEF = 512;
    localparam int SEG_WORDS_DEF = 8;

    // Buffer address width; depth is a power of two so this is exact.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/data_buffer_reader_if.sv
// rtl/data_buffer_reader_if.sv - segment output stream bundle
// Signals: m_valid, m_ready, m_data[data_bits], m_last (final word of a segment)
// Modports: master (reader side), slave (consumer side)
interface data_buffer_reader_if
    import tcp_buf_pkg::*;
#(
    parameter int data_bits = DATA_BITS_DEF
);
    logic                 m_valid;
    logic                 m_ready;
    logic [data_bits-1:0] m_data;
    logic                 m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/stream_skid_buffer.sv
// rtl/stream_skid_buffer.sv - 2-entry flow-through skid buffer for returned read data
// Ports: clk, resetn (async, active low), in_valid/in_data (word arriving this cycle),
//        out_valid/out_ready/out_data (downstream handshake), count (words held)
module stream_skid_buffer #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic [1:0]       count
);
    logic [width-1:0] slot [2];
    logic             head;
    logic [1:0]       cnt;
    logic             bypass;
    logic             push;
    logic             pop;

    assign count     = cnt;
    assign out_valid = (cnt != 2'd0) || in_valid;
    // Empty buffer presents the arriving word directly so the start latency stays
    // at one cycle after the read strobe; idle output is forced to zero.
    assign out_data  = (cnt != 2'd0) ? slot[head] : (in_valid ? in_data : '0);

    // Arriving word consumed in the same cycle never needs a slot.
    assign bypass = (cnt == 2'd0) && in_valid && out_ready;
    assign pop    = (cnt != 2'd0) && out_ready;
    // A full buffer can still accept when its head leaves this cycle; the freed
    // slot is exactly the tail position head ^ cnt[0].
    assign push   = in_valid && !bypass && ((cnt != 2'd2) || pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (pop) begin
                head <= ~head;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            slot[head ^ cnt[0]] <= in_data;
        end
    end

endmodule

// File: rtl/data_buffer_reader.sv
// rtl/data_buffer_reader.sv - reads buffered words in segments and streams them out
// Ports: clk, resetn (async, active low), wr_ptr (writer pointer + wrap bit), flush,
//        rd_en/rd_addr/rd_data (buffer read port, 1-cycle data latency),
//        rd_ptr (reader pointer + wrap bit), empty, m (segment stream master)
module data_buffer_reader
    import tcp_buf_pkg::*;
#(
    parameter int mem_depth = MEM_DEPTH_DEF,
    parameter int data_bits = DATA_BITS_DEF,
    parameter int seg_words = SEG_WORDS_DEF,
    localparam int addr_w   = addr_width(mem_depth)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [addr_w:0]       wr_ptr,
    input  logic                  flush,
    output logic                  rd_en,
    output logic [addr_w-1:0]     rd_addr,
    input  logic [data_bits-1:0]  rd_data,
    output logic [addr_w:0]       rd_ptr,
    output logic                  empty,
    data_buffer_reader_if.master  m
);
    localparam int cnt_w = addr_w + 1;
    localparam logic [cnt_w-1:0] seg_words_c = cnt_w'(seg_words);

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic [cnt_w-1:0] occupancy;
    logic [cnt_w-1:0] seg_len;
    logic [cnt_w-1:0] seg_len_nxt;
    logic [cnt_w-1:0] issued;
    logic             start_seg;
    logic             issue_last;
    logic             rd_en_q;
    logic             last_q;
    logic [1:0]       skid_count;
    logic             skid_pop;
    logic [2:0]       pending;
    logic [data_bits:0] skid_out;

    assign occupancy = wr_ptr - rd_ptr;
    assign empty     = (occupancy == '0);
    assign rd_addr   = rd_ptr[addr_w-1:0];

    assign skid_pop  = m.m_valid && m.m_ready;
    // Words that will still occupy the skid after this cycle: held plus arriving,
    // minus the one leaving. Netting the departure keeps 1 word/cycle with m_ready
    // high while never letting more than two words be owed to the skid.
    assign pending   = {1'b0, skid_count} + {2'b00, rd_en_q} - {2'b00, skid_pop};

    always_comb begin
        state_nxt   = state;
        start_seg   = 1'b0;
        rd_en       = 1'b0;
        issue_last  = 1'b0;
        seg_len_nxt = (occupancy >= seg_words_c) ? seg_words_c : occupancy;
        case (state)
            ST_IDLE: begin
                if ((occupancy >= seg_words_c) || (flush && !empty)) begin
                    start_seg = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if ((issued < seg_len) && (pending < 3'd2) && !empty) begin
                    rd_en      = 1'b1;
                    issue_last = (issued == (seg_len - cnt_w'(1)));
                    if (issue_last) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (m.m_valid && m.m_ready && m.m_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            rd_ptr  <= '0;
            seg_len <= '0;
            issued  <= '0;
            rd_en_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            // rd_en_q gates capture of returning data, so a read issued before a
            // reset is never accepted afterwards.
            rd_en_q <= rd_en;
            last_q  <= issue_last;
            if (rd_en) begin
                rd_ptr <= rd_ptr + cnt_w'(1);
            end
            if (start_seg) begin
                seg_len <= seg_len_nxt;
                issued  <= '0;
            end else if (rd_en) begin
                issued <= issued + cnt_w'(1);
            end
        end
    end

    // The last-word tag travels with its data through the skid.
    stream_skid_buffer #(
        .width(data_bits + 1)
    ) u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (rd_en_q),
        .in_data  ({last_q, rd_data}),
        .out_valid(m.m_valid),
        .out_ready(m.m_ready),
        .out_data (skid_out),
        .count    (skid_count)
    );

    assign m.m_last = skid_out[data_bits];
    assign m.m_data = skid_out[data_bits-1:0];

endmodule

// File: tb/tb_data_buffer_reader.sv
// tb/tb_data_buffer_reader.sv - scoreboard bench for data_buffer_reader
module tb_data_buffer_reader;
    localparam int DEPTH = 1024;
    localparam int DW    = 64;
    localparam int SEG   = 8;
    localparam int AW    = 10;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk    = 1'b0;
    logic          resetn = 1'b1;
    logic [AW:0]   wr_ptr = '0;
    logic          flush  = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [AW:0]   rd_ptr;
    logic          empty;

    data_buffer_reader_if #(.data_bits(DW)) m_if();

    data_buffer_reader #(
        .mem_depth(DEPTH),
        .data_bits(DW),
        .seg_words(SEG)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .wr_ptr (wr_ptr),
        .flush  (flush),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_ptr (rd_ptr),
        .empty  (empty),
        .m      (m_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];

    function automatic logic [DW-1:0] word_of(input int a);
        return {32'hC0DE0000 | 32'(a), ~(32'(a) * 32'd13)};
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    beat_t         sb[$];
    logic [AW-1:0] addr_q[$];
    int errors = 0;
    int checks = 0;
    int beats = 0;
    int rd_en_seen = 0;
    int valid_seen = 0;
    int stalls = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    beat_t         exp_b;
    logic [AW-1:0] exp_a;

    always @(negedge clk) begin
        if (resetn) begin
            if (rd_en) begin
                rd_en_seen++;
                checks++;
                if (wr_ptr == rd_ptr) begin
                    errors++;
                    $display("FAIL rd_en_when_empty: rd_en=1 with occupancy 0, required rd_en=0");
                end
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd_en: rd_addr=%0d, required no read", rd_addr);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (rd_addr !== exp_a) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d, required %0d", rd_addr, exp_a);
                    end
                end
            end
            if (prev_stall) begin
                stalls++;
                checks++;
                if (m_if.m_valid !== 1'b1 || m_if.m_data !== prev_data || m_if.m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             m_if.m_valid, m_if.m_data, m_if.m_last, prev_data, prev_last);
                end
            end
            if (m_if.m_valid) valid_seen++;
            if (m_if.m_valid && m_if.m_ready) begin
                beats++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h, required no beat", m_if.m_data);
                end else begin
                    exp_b = sb.pop_front();
                    if (m_if.m_data !== exp_b.data || m_if.m_last !== exp_b.last) begin
                        errors++;
                        $display("FAIL beat: got d=%h l=%b, required d=%h l=%b",
                                 m_if.m_data, m_if.m_last, exp_b.data, exp_b.last);
                    end
                end
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_data  = m_if.m_data;
            prev_last  = m_if.m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_seg(input int start, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            int a;
            a = (start + i) % DEPTH;
            addr_q.push_back(AW'(a));
            b.data = mem[a];
            b.last = (i == len - 1);
            sb.push_back(b);
        end
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || addr_q.size() != 0) && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats %0d reads outstanding, required 0", name, sb.size(), addr_q.size());
            sb.delete();
            addr_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, required 0", rd_en); end
        checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b, required 0", m_if.m_valid); end
        checks++; if (m_if.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b, required 0", m_if.m_last); end
        checks++; if (m_if.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h, required 0", m_if.m_data); end
        checks++; if (rd_ptr !== '0) begin errors++; $display("FAIL reset_rd_ptr: got %0d, required 0", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
        wr_ptr = 11'd5;
        #1;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty_tracks: got %b, required 0", empty); end
        wr_ptr = '0;
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_full_segment();
        int b0;
        b0 = beats;
        @(posedge clk); #1;
        push_seg(0, 8);
        wr_ptr = 11'd8;
        @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL decision_cycle_rd_en: got %b, required 0", rd_en); end
        @(negedge clk);
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL first_rd_en_latency: got %b, required 1", rd_en); end
        @(negedge clk);
        checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL first_m_valid_latency: got %b, required 1", m_if.m_valid); end
        wait_drain("full", 100);
        checks++; if (beats - b0 != 8) begin errors++; $display("FAIL full_beats: got %0d, required 8", beats - b0); end
        checks++; if (rd_ptr !== 11'd8) begin errors++; $display("FAIL full_rd_ptr: got %0d, required 8", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b, required 1", empty); end
    endtask

    task automatic test_flush();
        int b0;
        int r0;
        @(posedge clk); #1;
        push_seg(8, 3);
        wr_ptr = 11'd11;
        flush  = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_drain("flush", 100);
        b0 = beats;
        r0 = rd_en_seen;
        repeat (20) @(negedge clk);
        checks++; if (beats != b0 || rd_en_seen != r0) begin errors++; $display("FAIL flush_quiet: got %0d beats %0d reads, required 0", beats - b0, rd_en_seen - r0); end
        checks++; if (rd_ptr !== 11'd11) begin errors++; $display("FAIL flush_rd_ptr: got %0d, required 11", rd_ptr); end
    endtask

    task automatic test_stall();
        int n;
        int s0;
        s0 = stalls;
        @(posedge clk); #1;
        push_seg(11, 8);
        push_seg(19, 8);
        wr_ptr = 11'd27;
        n = 0;
        while ((sb.size() != 0 || addr_q.size() != 0) && n < 400) begin
            @(posedge clk); #1 m_if.m_ready = ~m_if.m_ready;
            n++;
        end
        m_if.m_ready = 1'b1;
        checks++;
        if (sb.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d beats outstanding, required 0", sb.size());
            sb.delete();
            addr_q.delete();
        end
        repeat (3) @(negedge clk);
        checks++; if (stalls == s0) begin errors++; $display("FAIL stall_seen: got 0 stall cycles, required >0"); end
        checks++; if (rd_ptr !== 11'd27) begin errors++; $display("FAIL stall_rd_ptr: got %0d, required 27", rd_ptr); end
    endtask

    task automatic test_reset_abort();
        int b0;
        int n;
        int r1;
        int v1;
        b0 = beats;
        @(posedge clk); #1;
        push_seg(27, 8);
        wr_ptr = 11'd35;
        n = 0;
        while (beats < b0 + 4 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        checks++; if (beats != b0 + 4) begin errors++; $display("FAIL abort_pre_beats: got %0d, required 4", beats - b0); end
        @(posedge clk); #1;
        resetn = 1'b0;
        wr_ptr = '0;
        #1;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL abort_rd_en: got %b, required 0", rd_en); end
        checks++; if (m_if.m_valid !== 1'b0 || m_if.m_last !== 1'b0 || m_if.m_data !== '0) begin errors++; $display("FAIL abort_stream: got v=%b l=%b d=%h, required 0", m_if.m_valid, m_if.m_last, m_if.m_data); end
        checks++; if (rd_ptr !== '0) begin errors++; $display("FAIL abort_rd_ptr: got %0d, required 0", rd_ptr); end
        sb.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        r1 = rd_en_seen;
        v1 = valid_seen;
        repeat (20) @(negedge clk);
        checks++; if (rd_en_seen != r1 || valid_seen != v1) begin errors++; $display("FAIL abort_stale: got %0d reads %0d valid cycles, required 0", rd_en_seen - r1, valid_seen - v1); end
        checks++; if (rd_ptr !== '0) begin errors++; $display("FAIL abort_rd_ptr_after: got %0d, required 0", rd_ptr); end
    endtask

    task automatic test_idle_flush();
        int r0;
        int v0;
        flush = 1'b1;
        r0 = rd_en_seen;
        v0 = valid_seen;
        repeat (50) @(negedge clk);
        checks++; if (rd_en_seen != r0) begin errors++; $display("FAIL idle_flush_rd_en: got %0d reads, required 0", rd_en_seen - r0); end
        checks++; if (valid_seen != v0) begin errors++; $display("FAIL idle_flush_m_valid: got %0d valid cycles, required 0", valid_seen - v0); end
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        for (int s = 0; s < 127; s++) push_seg(s * 8, 8);
        push_seg(1016, 4);
        wr_ptr = 11'd1020;
        wait_drain("prewrap", 1500);
        checks++; if (rd_ptr !== 11'd1020) begin errors++; $display("FAIL prewrap_rd_ptr: got %0d, required 1020", rd_ptr); end
        flush = 1'b0;
        push_seg(1020, 8);
        wr_ptr = 11'd1028;
        wait_drain("wrap", 100);
        checks++; if (rd_ptr !== 11'd1028) begin errors++; $display("FAIL wrap_rd_ptr: got %0d, required 1028", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b, required 1", empty); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = word_of(i);
        m_if.m_ready = 1'b1;
        test_reset();
        test_full_segment();
        test_flush();
        test_stall();
        test_reset_abort();
        test_idle_flush();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_buffer_reader.md
DATA_BUFFER_READER -- requirements
Module: data_buffer_reader

Interface
REQ-001 Parameter mem_depth, default 1024, buffer depth in words (power of two); ADDR_W = log2(mem_depth).
REQ-002 Parameter data_bits, default 512, word width.
REQ-003 Parameter seg_words, default 8, maximum words per output segment (1..mem_depth).
REQ-004 clk  input  1  single clock for the block; all logic on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 wr_ptr  input  ADDR_W+1  writer's binary pointer with wrap bit, same clock domain.
REQ-007 flush  input  1  level request to send a partial segment.
REQ-008 rd_en  output  1  buffer read strobe.
REQ-009 rd_addr  output  ADDR_W  buffer read address.
REQ-010 rd_data  input  data_bits  buffer read data, valid exactly one cycle after rd_en.
REQ-011 rd_ptr  output  ADDR_W+1  reader pointer with wrap bit, returned to the writer for its full calculation.
REQ-012 empty  output  1  high when occupancy is 0.
REQ-013 m_valid / m_ready / m_data[data_bits] / m_last  output / input / output / output  stream master; m_last marks the final word of a segment.

Function
REQ-014 Occupancy SHALL be (wr_ptr - rd_ptr) modulo 2^(ADDR_W+1); empty SHALL be combinational from it.
REQ-015 The FSM SHALL have three states: IDLE, FETCH, DRAIN.
REQ-016 IDLE->FETCH SHALL occur when occupancy >= seg_words, or when flush=1 and occupancy > 0; seg_len = min(seg_words, occupancy) SHALL be latched on that transition.
REQ-017 In FETCH, rd_en SHALL assert when words issued < seg_len and (words in flight + words held in skid) < 2.
REQ-018 rd_addr SHALL equal rd_ptr[ADDR_W-1:0]; rd_ptr SHALL increment by 1 on every rd_en cycle, wrapping through the wrap bit.
REQ-019 A 2-entry skid buffer SHALL capture rd_data one cycle after each rd_en; no read word SHALL be dropped or duplicated.
REQ-020 FETCH->DRAIN SHALL occur on the cycle the seg_len-th rd_en is issued.
REQ-021 DRAIN->IDLE SHALL occur on the handshake (m_valid & m_ready) of the m_last word.
REQ-022 m_valid SHALL be high whenever the skid holds a word; m_data and m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 m_last SHALL be 1 only on the seg_len-th word of the segment.
REQ-024 With m_ready held at 1, throughput SHALL be 1 word/cycle after a 2-cycle start latency (IDLE decision -> first rd_en -> m_valid).
REQ-025 flush deasserting mid-segment SHALL NOT shorten the latched seg_len.
REQ-026 Writes arriving mid-segment SHALL NOT extend the latched seg_len.
REQ-027 rd_en SHALL never assert when occupancy is 0.

Reset
REQ-028 On resetn=0: state=IDLE, rd_ptr=0, rd_en=0, skid empty, m_valid=0, m_last=0, m_data=0; empty reflects wr_ptr.
REQ-029 Reset asserted mid-segment SHALL abort immediately; read-data returns arriving after reset release SHALL be discarded.

Structure
REQ-030 mem_depth/data_bits defaults, ADDR_W derivation and the FSM state encoding SHALL live in a shared package tcp_buf_pkg, used also by data_buffer.
REQ-031 The 2-entry skid buffer SHALL be a sub-module named stream_skid_buffer.

Verification
REQ-032 wr_ptr 0->8, m_ready=1 -> 8 rd_en at addr 0..7, 8 beats of m_data equal to mem[0..7], m_last on beat 8, rd_ptr=8, empty=1.
REQ-033 wr_ptr=3, flush pulsed 1 cycle -> one 3-word segment, m_last on beat 3; no further output until occupancy >= 8.
REQ-034 wr_ptr=16, m_ready toggling 1/0 each cycle -> 2 segments of 8, data in order, m_data stable during stall, skid never overflows.
REQ-035 rd_ptr=1020 (wrap bit 0), wr_ptr advances to 1028 -> rd_addr sequence 1020..1023, 0..3; rd_ptr ends at 1028 with wrap bit 1.
REQ-036 resetn pulsed low after beat 4 of an 8-word segment -> all outputs at reset values same cycle; after release, no stale beats; rd_ptr=0.
REQ-037 Occupancy 0 with flush=1 held -> rd_en and m_valid remain 0 indefinitely.
